// File: rtl/ps2_mouse_rx_pkg.sv
// ps2_mouse_rx_pkg
// Shared constants, packet-bus field positions and the frame state type for
// the receive-only PS/2 mouse link layer.
package ps2_mouse_rx_pkg;

   localparam int FRAME_BITS = 11;   // start + 8 data + parity + stop
   localparam int PKT_BYTES  = 3;    // status, dx, dy
   localparam int SYNC_BIT   = 3;    // always 1 in a valid status byte

   // ps2_mouse bus layout
   localparam int PS2M_W       = 25;
   localparam int PS2M_TOGGLE  = 24;
   localparam int PS2M_DY_HI   = 23;
   localparam int PS2M_DY_LO   = 16;
   localparam int PS2M_DX_HI   = 15;
   localparam int PS2M_DX_LO   = 8;
   localparam int PS2M_STAT_HI = 7;
   localparam int PS2M_STAT_LO = 0;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

   // A frame is good when the stop bit is 1 and data+parity has odd weight.
   function automatic logic frame_good(input logic [7:0] d, input logic p,
                                       input logic stop_bit);
      return stop_bit & (^{d, p});
   endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// ps2_mouse_rx_if
// Output bus of the PS/2 mouse receiver.
//   ps2_mouse   : [24] toggle per packet, [23:16] dy, [15:8] dx, [7:0] status
//   err         : one-cycle pulse on any discarded byte, frame or packet
//   frame_state : current frame FSM state (observation only)
//   byte_idx    : packet byte index 0..2 (observation only)
// The bus carries no handshake: ps2_mouse is level data and a new packet is
// signalled solely by the toggle bit changing; consumers compare it against
// their last seen value. err is a single-cycle strobe with no back-pressure.
interface ps2_mouse_rx_if;
   import ps2_mouse_rx_pkg::*;

   logic [PS2M_W-1:0] ps2_mouse;
   logic              err;
   frame_state_t      frame_state;
   logic [1:0]        byte_idx;

   modport master (output ps2_mouse, output err, output frame_state, output byte_idx);
   modport slave  (input  ps2_mouse, input  err, input  frame_state, input  byte_idx);

endinterface

// File: rtl/ps2_byte_rx.sv
// ps2_byte_rx
// Conditions the raw PS/2 pads and deframes 11-bit bytes.
//   clk_sys, reset_n   : system clock, async active-low reset
//   ps2_clk, ps2_data  : raw pad inputs (asynchronous)
//   rx_byte            : last deframed data byte (held)
//   byte_ok, byte_bad  : one-cycle strobes; byte_bad also fires on bit timeout
//   fall               : registered filtered-clock falling edge
//   state              : frame FSM state
module ps2_byte_rx
   import ps2_mouse_rx_pkg::*;
#(
   parameter int FILTER      = 8,
   parameter int BIT_TIMEOUT = 128000
) (
   input  logic         clk_sys,
   input  logic         reset_n,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic [7:0]   rx_byte,
   output logic         byte_ok,
   output logic         byte_bad,
   output logic         fall,
   output frame_state_t state
);

   localparam int FW = $clog2(FILTER + 1);
   localparam int TW = $clog2(BIT_TIMEOUT + 1);

   logic          clk_meta, clk_s, dat_meta, dat_s;
   logic          filt;
   logic [FW-1:0] fcnt;

   // Two-flop synchronisers; lines idle high.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta <= 1'b1;
         clk_s    <= 1'b1;
         dat_meta <= 1'b1;
         dat_s    <= 1'b1;
      end else begin
         clk_meta <= ps2_clk;
         clk_s    <= clk_meta;
         dat_meta <= ps2_data;
         dat_s    <= dat_meta;
      end
   end

   // Glitch filter: filt follows clk_s only after FILTER consecutive
   // differing samples. fall is raised in the same cycle filt drops, so the
   // edge is registered without an extra delay stage.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         filt <= 1'b1;
         fcnt <= '0;
         fall <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_s == filt) begin
            fcnt <= '0;
         end else if (fcnt == FW'(FILTER - 1)) begin
            filt <= clk_s;
            fcnt <= '0;
            fall <= filt & ~clk_s;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

   // Frame FSM
   frame_state_t  state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bcnt_q, bcnt_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          ok_d, bad_d;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         bcnt_q   <= '0;
         par_q    <= 1'b0;
         tmo_q    <= '0;
         byte_ok  <= 1'b0;
         byte_bad <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bcnt_q   <= bcnt_d;
         par_q    <= par_d;
         tmo_q    <= tmo_d;
         byte_ok  <= ok_d;
         byte_bad <= bad_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcnt_d  = bcnt_q;
      par_d   = par_q;
      tmo_d   = tmo_q;
      ok_d    = 1'b0;
      bad_d   = 1'b0;
      if (state_q == IDLE) begin
         tmo_d = '0;
         // A high data bit on an edge in IDLE is a spurious edge: ignored.
         if (fall && !dat_s) begin
            state_d = DATA;
            bcnt_d  = '0;
         end
      end else if (fall) begin
         // An edge always beats a timeout expiring in the same cycle.
         tmo_d = '0;
         case (state_q)
            DATA: begin
               shift_d = {dat_s, shift_q[7:1]};
               bcnt_d  = bcnt_q + 3'd1;
               if (bcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = dat_s;
               state_d = STOP;
            end
            STOP: begin
               if (frame_good(shift_q, par_q, dat_s)) ok_d = 1'b1;
               else                                   bad_d = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (tmo_q == TW'(BIT_TIMEOUT - 1)) begin
         state_d = IDLE;
         bad_d   = 1'b1;
         tmo_d   = '0;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   assign rx_byte = shift_q;
   assign state   = state_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx
// Receive-only PS/2 mouse link layer: assembles 3-byte movement packets.
//   clk_sys, reset_n   : system clock, async active-low reset
//   ps2_clk, ps2_data  : raw pad inputs (never driven)
//   bus                : ps2_mouse packet bus, err strobe, observation signals
module ps2_mouse_rx
   import ps2_mouse_rx_pkg::*;
#(
   parameter int FILTER      = 8,
   parameter int BIT_TIMEOUT = 128000,
   parameter int PKT_TIMEOUT = 640000
) (
   input  logic           clk_sys,
   input  logic           reset_n,
   input  logic           ps2_clk,
   input  logic           ps2_data,
   ps2_mouse_rx_if.master bus
);

   localparam int          PW       = $clog2(PKT_TIMEOUT + 1);
   localparam logic [1:0]  LAST_IDX = 2'(PKT_BYTES - 1);

   logic [7:0]   rx_byte;
   logic         byte_ok, byte_bad, fall;
   frame_state_t state;

   ps2_byte_rx #(
      .FILTER      (FILTER),
      .BIT_TIMEOUT (BIT_TIMEOUT)
   ) u_byte_rx (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .byte_ok  (byte_ok),
      .byte_bad (byte_bad),
      .fall     (fall),
      .state    (state)
   );

   logic [1:0]        idx_q, idx_d;
   logic [7:0]        b0_q, b0_d, b1_q, b1_d;
   logic [PS2M_W-1:0] mouse_q, mouse_d;
   logic              err_q, err_d;
   logic [PW-1:0]     ptmo_q, ptmo_d;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         idx_q   <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         mouse_q <= '0;
         err_q   <= 1'b0;
         ptmo_q  <= '0;
      end else begin
         idx_q   <= idx_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         mouse_q <= mouse_d;
         err_q   <= err_d;
         ptmo_q  <= ptmo_d;
      end
   end

   always_comb begin
      idx_d   = idx_q;
      b0_d    = b0_q;
      b1_d    = b1_q;
      mouse_d = mouse_q;
      err_d   = 1'b0;
      ptmo_d  = '0;
      if (byte_bad) begin
         idx_d = '0;
         err_d = 1'b1;
      end else if (byte_ok) begin
         if (idx_q == 2'd0) begin
            // Resync: a status byte always has bit 3 set.
            if (rx_byte[SYNC_BIT]) begin
               b0_d  = rx_byte;
               idx_d = 2'd1;
            end else begin
               err_d = 1'b1;
            end
         end else if (idx_q != LAST_IDX) begin
            b1_d  = rx_byte;
            idx_d = idx_q + 2'd1;
         end else begin
            mouse_d[PS2M_TOGGLE]               = ~mouse_q[PS2M_TOGGLE];
            mouse_d[PS2M_DY_HI:PS2M_DY_LO]     = rx_byte;
            mouse_d[PS2M_DX_HI:PS2M_DX_LO]     = b1_q;
            mouse_d[PS2M_STAT_HI:PS2M_STAT_LO] = b0_q;
            idx_d                              = '0;
         end
      end else if (idx_q != 2'd0 && state == IDLE) begin
         // On an edge the count is held: a start bit moves the frame out of
         // IDLE (clearing the count next cycle), a spurious edge does not.
         if (fall) begin
            ptmo_d = ptmo_q;
         end else if (ptmo_q == PW'(PKT_TIMEOUT - 1)) begin
            idx_d = '0;
            err_d = 1'b1;
         end else begin
            ptmo_d = ptmo_q + PW'(1);
         end
      end
   end

   assign bus.ps2_mouse   = mouse_q;
   assign bus.err         = err_q;
   assign bus.frame_state = state;
   assign bus.byte_idx    = idx_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb_ps2_mouse_rx
// Directed bench for ps2_mouse_rx with shortened timeouts so every scenario
// fits in a short run. Expected values are hand-computed per scenario.
module tb_ps2_mouse_rx;
   import ps2_mouse_rx_pkg::*;

   localparam int FILTER      = 8;
   localparam int BIT_TIMEOUT = 300;
   localparam int PKT_TIMEOUT = 1500;
   localparam int HALF        = 25;   // PS/2 clock half period in clk_sys cycles
   localparam int GAP         = 100;  // idle time after each frame

   logic clk_sys = 1'b0;
   logic reset_n;
   logic ps2_clk;
   logic ps2_data;

   int tests_run    = 0;
   int tests_failed = 0;
   int err_cnt      = 0;
   int e0;

   ps2_mouse_rx_if mif ();

   ps2_mouse_rx #(
      .FILTER      (FILTER),
      .BIT_TIMEOUT (BIT_TIMEOUT),
      .PKT_TIMEOUT (PKT_TIMEOUT)
   ) dut (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (mif)
   );

   // clock / reset
   always #5 clk_sys = ~clk_sys;

   // err pulse monitor: each high cycle counts once
   always @(posedge clk_sys) begin
      if (mif.err === 1'b1) err_cnt <= err_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
      return {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
   endfunction

   // driver: sends the first n bits of a frame LSB first; optional sub-FILTER
   // low glitch in each clock-high phase
   task automatic send_bits(input logic [10:0] f, input int n, input logic glitch);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         if (glitch) begin
            wait_cyc(5);
            ps2_clk = 1'b0;
            wait_cyc(FILTER - 1);
            ps2_clk = 1'b1;
            wait_cyc(HALF - 5 - (FILTER - 1));
         end else begin
            wait_cyc(HALF);
         end
         ps2_clk = 1'b0;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_cyc(GAP);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic glitch);
      send_bits(make_frame(b, bad_par), FRAME_BITS, glitch);
   endtask

   initial begin
      reset_n  = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(5);
      check_eq("reset_mouse", 32'(mif.ps2_mouse), 32'h0);
      check_eq("reset_err", 32'(mif.err), 32'h0);
      check_eq("reset_state", 32'(mif.frame_state), 32'(IDLE));
      check_eq("reset_idx", 32'(mif.byte_idx), 32'h0);
      reset_n = 1'b1;
      wait_cyc(5);

      // 1: clean packet
      e0 = err_cnt;
      send_byte(8'h09, 1'b0, 1'b0);
      send_byte(8'h05, 1'b0, 1'b0);
      send_byte(8'hFB, 1'b0, 1'b0);
      check_eq("pkt1_mouse", 32'(mif.ps2_mouse), 32'h1FB0509);
      check_eq("pkt1_err", 32'(err_cnt - e0), 32'd0);

      // 2: bad parity drops partial packet
      e0 = err_cnt;
      send_byte(8'h09, 1'b0, 1'b0);
      send_byte(8'h05, 1'b1, 1'b0);
      check_eq("badpar_hold", 32'(mif.ps2_mouse), 32'h1FB0509);
      check_eq("badpar_idx", 32'(mif.byte_idx), 32'h0);
      send_byte(8'h08, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      check_eq("badpar_mouse", 32'(mif.ps2_mouse), 32'h0000008);
      check_eq("badpar_err", 32'(err_cnt - e0), 32'd1);

      // 3: resync on bit3=0
      e0 = err_cnt;
      send_byte(8'h05, 1'b0, 1'b0);
      send_byte(8'h0A, 1'b0, 1'b0);
      send_byte(8'h10, 1'b0, 1'b0);
      send_byte(8'hF0, 1'b0, 1'b0);
      check_eq("resync_mouse", 32'(mif.ps2_mouse), 32'h1F0100A);
      check_eq("resync_err", 32'(err_cnt - e0), 32'd1);

      // 4: bit timeout mid-frame
      e0 = err_cnt;
      send_bits(make_frame(8'hA5, 1'b0), 5, 1'b0);
      check_eq("bittmo_inframe", 32'(mif.frame_state), 32'(DATA));
      wait_cyc(BIT_TIMEOUT + 50);
      check_eq("bittmo_state", 32'(mif.frame_state), 32'(IDLE));
      check_eq("bittmo_err", 32'(err_cnt - e0), 32'd1);
      send_byte(8'h08, 1'b0, 1'b0);
      send_byte(8'h01, 1'b0, 1'b0);
      send_byte(8'h02, 1'b0, 1'b0);
      check_eq("bittmo_mouse", 32'(mif.ps2_mouse), 32'h0020108);

      // 5: packet timeout, then glitchy clock packet
      e0 = err_cnt;
      send_byte(8'h08, 1'b0, 1'b0);
      send_byte(8'h01, 1'b0, 1'b0);
      check_eq("pkttmo_idx_pre", 32'(mif.byte_idx), 32'd2);
      wait_cyc(PKT_TIMEOUT + 100);
      check_eq("pkttmo_idx", 32'(mif.byte_idx), 32'd0);
      check_eq("pkttmo_err", 32'(err_cnt - e0), 32'd1);
      send_byte(8'h02, 1'b0, 1'b0);
      check_eq("pkttmo_err2", 32'(err_cnt - e0), 32'd2);
      check_eq("pkttmo_hold", 32'(mif.ps2_mouse), 32'h0020108);
      e0 = err_cnt;
      send_byte(8'h09, 1'b0, 1'b1);
      send_byte(8'h05, 1'b0, 1'b1);
      send_byte(8'hFB, 1'b0, 1'b1);
      check_eq("glitch_mouse", 32'(mif.ps2_mouse), 32'h1FB0509);
      check_eq("glitch_err", 32'(err_cnt - e0), 32'd0);

      // 6: async reset mid-packet
      send_byte(8'h09, 1'b0, 1'b0);
      send_byte(8'hFF, 1'b0, 1'b0);
      reset_n = 1'b0;
      #1;
      check_eq("rst_mouse", 32'(mif.ps2_mouse), 32'h0);
      check_eq("rst_err", 32'(mif.err), 32'h0);
      check_eq("rst_idx", 32'(mif.byte_idx), 32'h0);
      wait_cyc(3);
      reset_n = 1'b1;
      wait_cyc(5);
      e0 = err_cnt;
      send_byte(8'h09, 1'b0, 1'b0);
      send_byte(8'hFF, 1'b0, 1'b0);
      send_byte(8'h01, 1'b0, 1'b0);
      check_eq("rst_pkt_mouse", 32'(mif.ps2_mouse), 32'h101FF09);
      check_eq("rst_pkt_err", 32'(err_cnt - e0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
